// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_REQ      = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_DM = 1'b1
    } arb_owner_t;

    localparam int unsigned ARB_MAX_DSTREAK_DEF = 4;
    localparam int unsigned ARB_ADDR_W_DEF      = 32;
    localparam int unsigned ARB_DATA_W_DEF      = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage,
// one outstanding transaction at a time, with bounded IF starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ARB_ADDR_W_DEF,
    parameter int unsigned DATA_W      = ARB_DATA_W_DEF,
    parameter int unsigned MAX_DSTREAK = ARB_MAX_DSTREAK_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,
    input  logic                  dm_req_valid,
    input  logic                  dm_req_we,
    input  logic [ADDR_W-1:0]     dm_req_addr,
    input  logic [DATA_W-1:0]     dm_req_wdata,
    input  logic [DATA_W/8-1:0]   dm_req_be,
    output logic                  dm_rsp_valid,
    output logic [DATA_W-1:0]     dm_rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    output logic                  stall_if_req,
    output logic                  stall_dm_req,
    output logic                  protocol_err
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t            state, state_nxt;
    arb_owner_t            owner, owner_nxt;
    logic [STREAK_W-1:0]   streak, streak_nxt;
    logic                  squash, squash_nxt;
    logic                  err_nxt;
    logic                  we_nxt;
    logic [ADDR_W-1:0]     addr_nxt;
    logic [DATA_W-1:0]     wdata_nxt;
    logic [BE_W-1:0]       be_nxt;
    logic                  grant_dm;
    logic                  rsp_fire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ARB_IDLE;
            owner         <= ARB_OWN_DM;
            streak        <= '0;
            squash        <= 1'b0;
            protocol_err  <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            streak        <= streak_nxt;
            squash        <= squash_nxt;
            protocol_err  <= err_nxt;
            mem_req_we    <= we_nxt;
            mem_req_addr  <= addr_nxt;
            mem_req_wdata <= wdata_nxt;
            mem_req_be    <= be_nxt;
        end
    end

    // DM wins unless a waiting IF has already sat out MAX_DSTREAK DM grants.
    assign grant_dm = dm_req_valid && !(if_req_valid && (streak == STREAK_MAX));

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        streak_nxt = streak;
        squash_nxt = squash;
        err_nxt    = protocol_err;
        we_nxt     = mem_req_we;
        addr_nxt   = mem_req_addr;
        wdata_nxt  = mem_req_wdata;
        be_nxt     = mem_req_be;

        case (state)
            ARB_IDLE: begin
                squash_nxt = 1'b0;
                if (!if_req_valid) begin
                    streak_nxt = '0;
                end
                if (grant_dm) begin
                    owner_nxt = ARB_OWN_DM;
                    we_nxt    = dm_req_we;
                    addr_nxt  = dm_req_addr;
                    wdata_nxt = dm_req_wdata;
                    be_nxt    = dm_req_be;
                    state_nxt = ARB_REQ;
                    if (if_req_valid && (streak != STREAK_MAX)) begin
                        streak_nxt = streak + STREAK_W'(1);
                    end
                end else if (if_req_valid) begin
                    owner_nxt  = ARB_OWN_IF;
                    we_nxt     = 1'b0;
                    addr_nxt   = if_req_addr;
                    wdata_nxt  = '0;
                    be_nxt     = '1;
                    streak_nxt = '0;
                    state_nxt  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if ((owner == ARB_OWN_IF) && !if_req_valid) begin
                    squash_nxt = 1'b1;
                end
                if (mem_req_ready) begin
                    state_nxt = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if ((owner == ARB_OWN_IF) && !if_req_valid) begin
                    squash_nxt = 1'b1;
                end
                if (mem_rsp_valid) begin
                    squash_nxt = 1'b0;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase

        if (mem_rsp_valid && (state != ARB_WAIT_RSP)) begin
            err_nxt = 1'b1;
        end
    end

    // A flushed fetch still drains its response, but nobody sees it.
    assign rsp_fire      = (state == ARB_WAIT_RSP) && mem_rsp_valid;
    assign if_rsp_valid  = rsp_fire && (owner == ARB_OWN_IF) && !squash && if_req_valid;
    assign dm_rsp_valid  = rsp_fire && (owner == ARB_OWN_DM);
    assign if_rsp_data   = if_rsp_valid ? mem_rsp_rdata : '0;
    assign dm_rsp_rdata  = dm_rsp_valid ? mem_rsp_rdata : '0;
    assign mem_req_valid = (state == ARB_REQ);
    assign stall_if_req  = resetn && if_req_valid && !if_rsp_valid;
    assign stall_dm_req  = resetn && dm_req_valid && !dm_rsp_valid;

    // DM may not withdraw a request it has been granted.
    always_ff @(posedge clk) begin
        if (resetn && (state != ARB_IDLE) && (owner == ARB_OWN_DM)) begin
            assert (dm_req_valid);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        stall_if_req;
    logic        stall_dm_req;
    logic        protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .stall_if_req(stall_if_req), .stall_dm_req(stall_dm_req), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i initialised to 0xA500_0000|i, response 1 or 2 cycles after accept.
    logic [31:0] mem [0:255];
    logic        lat2;
    logic        inject;
    logic        p1, p2;
    logic [31:0] d1, d2;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1 <= 1'b0; p2 <= 1'b0; d1 <= '0; d2 <= '0;
        end else begin
            p1 <= mem_req_valid && mem_req_ready;
            d1 <= mem[mem_req_addr[9:2]];
            p2 <= p1;
            d2 <= d1;
        end
    end

    always @(posedge clk) begin
        if (resetn && mem_req_valid && mem_req_ready && mem_req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_req_be[b]) mem[mem_req_addr[9:2]][8*b +: 8] <= mem_req_wdata[8*b +: 8];
            end
        end
    end

    assign mem_rsp_valid = inject || (lat2 ? p2 : p1);
    assign mem_rsp_rdata = lat2 ? d2 : d1;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; if_req_valid = 1'b1; dm_req_valid = 1'b1; mem_req_ready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset.req_valid got %0h exp 0", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset.req_addr got %0h exp 0", mem_req_addr); end
        n_cmp++; if (mem_req_be !== 4'h0) begin n_bad++; $display("FAIL reset.req_be got %0h exp 0", mem_req_be); end
        n_cmp++; if (mem_req_we !== 1'b0) begin n_bad++; $display("FAIL reset.req_we got %0h exp 0", mem_req_we); end
        n_cmp++; if (stall_if_req !== 1'b0) begin n_bad++; $display("FAIL reset.stall_if got %0h exp 0", stall_if_req); end
        n_cmp++; if (stall_dm_req !== 1'b0) begin n_bad++; $display("FAIL reset.stall_dm got %0h exp 0", stall_dm_req); end
        n_cmp++; if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset.rsp_valid got %0h/%0h exp 0/0", if_rsp_valid, dm_rsp_valid); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset.protocol_err got %0h exp 0", protocol_err); end
        if_req_valid = 1'b0; dm_req_valid = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset.idle_valid got %0h exp 0", mem_req_valid); end
    endtask

    task automatic test_if_only;
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        @(negedge clk);
        n_cmp++; if (stall_if_req !== 1'b1) begin n_bad++; $display("FAIL if_only.stall_T got %0h exp 1", stall_if_req); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL if_only.valid_T got %0h exp 0", mem_req_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL if_only.valid_T1 got %0h exp 1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 32'h100) begin n_bad++; $display("FAIL if_only.addr got %0h exp 100", mem_req_addr); end
        n_cmp++; if (mem_req_be !== 4'hF || mem_req_we !== 1'b0) begin n_bad++; $display("FAIL if_only.be_we got %0h/%0h exp f/0", mem_req_be, mem_req_we); end
        n_cmp++; if (stall_if_req !== 1'b1) begin n_bad++; $display("FAIL if_only.stall_T1 got %0h exp 1", stall_if_req); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (if_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL if_only.rsp_T2 got %0h exp 1", if_rsp_valid); end
        n_cmp++; if (if_rsp_data !== 32'hA500_0040) begin n_bad++; $display("FAIL if_only.data got %0h exp a5000040", if_rsp_data); end
        n_cmp++; if (stall_if_req !== 1'b0) begin n_bad++; $display("FAIL if_only.stall_T2 got %0h exp 0", stall_if_req); end
        n_cmp++; if (dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL if_only.dm_rsp got %0h exp 0", dm_rsp_valid); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL if_only.rsp_T3 got %0h exp 0", if_rsp_valid); end
    endtask

    task automatic test_tie;
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'h104;
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h200;
        dm_req_wdata = 32'h1234_5678; dm_req_be = 4'b0011;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin n_bad++; $display("FAIL tie.dm_first got %0h/%0h exp 1/200", mem_req_valid, mem_req_addr); end
        n_cmp++; if (mem_req_we !== 1'b1 || mem_req_be !== 4'b0011) begin n_bad++; $display("FAIL tie.we_be got %0h/%0h exp 1/3", mem_req_we, mem_req_be); end
        n_cmp++; if (mem_req_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL tie.wdata got %0h exp 12345678", mem_req_wdata); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (dm_rsp_valid !== 1'b1 || stall_dm_req !== 1'b0) begin n_bad++; $display("FAIL tie.dm_rsp got %0h/%0h exp 1/0", dm_rsp_valid, stall_dm_req); end
        n_cmp++; if (stall_if_req !== 1'b1 || if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL tie.if_waits got %0h/%0h exp 1/0", stall_if_req, if_rsp_valid); end
        next_cycle();
        dm_req_valid = 1'b0; dm_req_we = 1'b0;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin n_bad++; $display("FAIL tie.if_second got %0h/%0h exp 1/104", mem_req_valid, mem_req_addr); end
        n_cmp++; if (mem_req_we !== 1'b0 || mem_req_be !== 4'hF) begin n_bad++; $display("FAIL tie.if_we_be got %0h/%0h exp 0/f", mem_req_we, mem_req_be); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hA500_0041) begin n_bad++; $display("FAIL tie.if_rsp got %0h/%0h exp 1/a5000041", if_rsp_valid, if_rsp_data); end
        next_cycle();
        if_req_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_addr [6];
        int ng = 0;
        int n_ifr = 0;
        int n_dmr = 0;
        exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'h300;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h200; dm_req_be = 4'hF;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (mem_req_valid && ng < 6) begin
                n_cmp++; if (mem_req_addr !== exp_addr[ng]) begin n_bad++; $display("FAIL b2b.grant%0d got %0h exp %0h", ng, mem_req_addr, exp_addr[ng]); end
                if (ng == 3) begin
                    n_cmp++; if (dut.streak !== 3'd4) begin n_bad++; $display("FAIL b2b.streak_sat got %0d exp 4", dut.streak); end
                end
                if (ng == 4) begin
                    n_cmp++; if (dut.streak !== 3'd0) begin n_bad++; $display("FAIL b2b.streak_clr got %0d exp 0", dut.streak); end
                end
                ng++;
            end
            if (dm_rsp_valid) begin
                n_dmr++;
                n_cmp++; if (dm_rsp_rdata !== 32'hA500_5678) begin n_bad++; $display("FAIL b2b.dm_data got %0h exp a5005678", dm_rsp_rdata); end
            end
            if (if_rsp_valid) begin
                n_ifr++;
                n_cmp++; if (if_rsp_data !== 32'hA500_00C0) begin n_bad++; $display("FAIL b2b.if_data got %0h exp a50000c0", if_rsp_data); end
            end
            next_cycle();
        end
        if_req_valid = 1'b0; dm_req_valid = 1'b0;
        n_cmp++; if (ng != 6) begin n_bad++; $display("FAIL b2b.grant_count got %0d exp 6", ng); end
        n_cmp++; if (n_dmr != 5 || n_ifr != 1) begin n_bad++; $display("FAIL b2b.rsp_count got dm=%0d if=%0d exp dm=5 if=1", n_dmr, n_ifr); end
    endtask

    task automatic test_ready_stall;
        next_cycle();
        mem_req_ready = 1'b0;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h208;
        dm_req_wdata = 32'hDEAD_BEEF; dm_req_be = 4'hF;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h208 || mem_req_wdata !== 32'hDEAD_BEEF)
                begin n_bad++; $display("FAIL stall.hold%0d got %0h/%0h/%0h exp 1/208/deadbeef", k, mem_req_valid, mem_req_addr, mem_req_wdata); end
            n_cmp++; if (dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall.early_rsp%0d got %0h exp 0", k, dm_rsp_valid); end
            next_cycle();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stall.accept got %0h exp 1", mem_req_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (dm_rsp_valid !== 1'b1 || dm_rsp_rdata !== 32'hA500_0082) begin n_bad++; $display("FAIL stall.rsp got %0h/%0h exp 1/a5000082", dm_rsp_valid, dm_rsp_rdata); end
        next_cycle();
        dm_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall.idle got %0h exp 0", mem_req_valid); end
    endtask

    task automatic test_squash;
        next_cycle();
        lat2 = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h104;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104) begin n_bad++; $display("FAIL squash.req got %0h/%0h exp 1/104", mem_req_valid, mem_req_addr); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_if_req !== 1'b0 || if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL squash.flush got %0h/%0h exp 0/0", stall_if_req, if_rsp_valid); end
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'h108;
        @(negedge clk);
        n_cmp++; if (if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL squash.suppress got %0h exp 0", if_rsp_valid); end
        n_cmp++; if (stall_if_req !== 1'b1) begin n_bad++; $display("FAIL squash.stall got %0h exp 1", stall_if_req); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h108) begin n_bad++; $display("FAIL squash.next_req got %0h/%0h exp 1/108", mem_req_valid, mem_req_addr); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hA500_0042) begin n_bad++; $display("FAIL squash.next_rsp got %0h/%0h exp 1/a5000042", if_rsp_valid, if_rsp_data); end
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL squash.perr got %0h exp 0", protocol_err); end
    endtask

    task automatic test_reset_mid;
        next_cycle();
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h200; dm_req_be = 4'hF;
        next_cycle();
        next_cycle();
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mid.req got %0h/%0h exp 0/0", mem_req_valid, mem_req_addr); end
        n_cmp++; if (dm_rsp_valid !== 1'b0 || stall_dm_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid.dm got %0h/%0h exp 0/0", dm_rsp_valid, stall_dm_req); end
        next_cycle();
        dm_req_valid = 1'b0;
        resetn = 1'b1;
        next_cycle();
        inject = 1'b1;
        @(negedge clk);
        n_cmp++; if (dm_rsp_valid !== 1'b0 || protocol_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid.late got %0h/%0h exp 0/0", dm_rsp_valid, protocol_err); end
        next_cycle();
        inject = 1'b0;
        @(negedge clk);
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL rst_mid.perr_set got %0h exp 1", protocol_err); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL rst_mid.perr_sticky got %0h exp 1", protocol_err); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        resetn = 1'b0; lat2 = 1'b0; inject = 1'b0; mem_req_ready = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_be = '0;
        test_reset();
        test_if_only();
        test_tie();
        test_back_to_back();
        test_ready_stall();
        test_squash();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
